// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out shift register.
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // Width of the in-word bit counter; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts enabled bits within a word; wraps to 0 and strobes `last` on the final bit.
// Counter updates one edge after each enabled bit; last is combinational on enable.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          enable,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
  output logic                          last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    last  = enable && !clear && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

endmodule

// File: rtl/sipo_shift_register.sv
// Serial-in/parallel-out register, LSB first; word visible 1 edge after its last bit.
// No serial backpressure; SIPO_OVERRUN_EN drops unacked words and flags overrun.
module sipo_shift_register
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          sr_in,
  input  logic                          out_ack,
  output logic [WIDTH-1:0]              p_out,
  output logic                          out_valid,
`ifdef SIPO_OVERRUN_EN
  output logic                          overrun,
`endif
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  // Only WIDTH-1 earlier bits need storing; the current sr_in completes the word.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] shifted;
  logic             last;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enable  (enable),
    .bit_cnt (bit_cnt),
    .last    (last)
  );

`ifdef SIPO_OVERRUN_EN
  logic overrun_q, overrun_d;
`endif

  always_comb begin
    shifted     = {sr_in, sr_q};
    sr_d        = sr_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q;
`ifdef SIPO_OVERRUN_EN
    overrun_d   = overrun_q;
`endif
    if (clear) begin
      sr_d        = '0;
      p_out_d     = '0;
      out_valid_d = 1'b0;
`ifdef SIPO_OVERRUN_EN
      overrun_d   = 1'b0;
`endif
    end else begin
      if (enable) begin
        sr_d = shifted[WIDTH-1:1];
      end
      if (last) begin
        if (!out_valid_q || out_ack) begin
          p_out_d     = shifted;
          out_valid_d = 1'b1;
        end else begin
`ifdef SIPO_OVERRUN_EN
          overrun_d   = 1'b1;
`else
          p_out_d     = shifted;
`endif
        end
      end else if (out_ack) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      p_out_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SIPO_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      sr_q        <= sr_d;
      p_out_q     <= p_out_d;
      out_valid_q <= out_valid_d;
`ifdef SIPO_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign p_out     = p_out_q;
  assign out_valid = out_valid_q;
`ifdef SIPO_OVERRUN_EN
  assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_sipo_shift_register.sv
// Self-checking bench for sipo_shift_register (WIDTH=8); vector table plus corner sequences.
module tb_sipo_shift_register;

  logic       clk = 1'b0;
  logic       rst, clear, enable, sr_in, out_ack;
  logic [7:0] p_out;
  logic       out_valid;
  logic [2:0] bit_cnt;
`ifdef SIPO_OVERRUN_EN
  logic       overrun;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_shift_register #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .enable    (enable),
    .sr_in     (sr_in),
    .out_ack   (out_ack),
    .p_out     (p_out),
    .out_valid (out_valid),
`ifdef SIPO_OVERRUN_EN
    .overrun   (overrun),
`endif
    .bit_cnt   (bit_cnt)
  );

  typedef struct {
    logic [7:0] word;
    int         gap_at;
    int         gap_len;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive n bits of w LSB first; optional idle gap after bit gap_at.
  task automatic send_bits(input logic [7:0] w, input int n, input int gap_at, input int gap_len,
                           input logic ack_last, input logic push, input logic [7:0] exp_word);
    for (int i = 0; i < n; i++) begin
      sr_in   = w[i];
      enable  = 1'b1;
      out_ack = ack_last && (i == n - 1);
      if (push && i == n - 1) exp_q.push_back(exp_word);
      tick;
      enable  = 1'b0;
      out_ack = 1'b0;
      if (i == gap_at) begin
        repeat (gap_len) begin
          sr_in = 1'($urandom_range(0, 1));
          tick;
        end
        check("gap_bit_cnt", 32'(bit_cnt), 32'(gap_at + 1));
      end
    end
    sr_in = 1'b0;
  endtask

  task automatic expect_word(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got p_out %0h with no expected word queued", name, p_out);
    end else begin
      e = exp_q.pop_front();
      check({name, "_p_out"}, 32'(p_out), 32'(e));
      check({name, "_valid"}, 32'(out_valid), 32'd1);
    end
  endtask

  task automatic ack_idle;
    enable  = 1'b0;
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_p_out"}, 32'(p_out), 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_bit_cnt"}, 32'(bit_cnt), 32'd0);
`ifdef SIPO_OVERRUN_EN
    check({name, "_overrun"}, 32'(overrun), 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{8'hAA, -1, 0};
    vecs[1] = '{8'h3C,  3, 3};
    vecs[2] = '{8'h01, -1, 0};
    vecs[3] = '{8'h80,  0, 2};
    vecs[4] = '{8'hFF,  6, 1};
    vecs[5] = '{8'h00, -1, 0};

    rst = 1'b1; clear = 1'b0; enable = 1'b0; sr_in = 1'b0; out_ack = 1'b0;
    tick;
    tick;
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[v]) begin
      ack_idle;
      check("pre_vec_valid", 32'(out_valid), 32'd0);
      send_bits(vecs[v].word, 8, vecs[v].gap_at, vecs[v].gap_len, 1'b0, 1'b1, vecs[v].word);
      expect_word("vec");
      check("vec_bit_cnt", 32'(bit_cnt), 32'd0);
    end

    // Ack clears valid and leaves the word; ack while idle is ignored.
    ack_idle;
    check("ack_clear_valid", 32'(out_valid), 32'd0);
    check("ack_hold_p_out", 32'(p_out), 32'h00);
    ack_idle;
    check("ack_idle_valid", 32'(out_valid), 32'd0);

    // Ack coincident with completion of the next word.
    send_bits(8'hAA, 8, -1, 0, 1'b0, 1'b1, 8'hAA);
    expect_word("aa_before_ack");
    send_bits(8'h55, 8, -1, 0, 1'b1, 1'b1, 8'h55);
    expect_word("ack_coincident");

    // Reset mid-word discards partial bits.
    ack_idle;
    send_bits(8'h1F, 5, -1, 0, 1'b0, 1'b0, 8'h00);
    check("partial_bit_cnt", 32'(bit_cnt), 32'd5);
    rst = 1'b1; enable = 1'b1; sr_in = 1'b1;
    tick;
    rst = 1'b0; enable = 1'b0; sr_in = 1'b0;
    check_zero("mid_rst");
    send_bits(8'hF0, 8, -1, 0, 1'b0, 1'b1, 8'hF0);
    expect_word("after_rst");

    // Clear mid-word behaves like reset.
    send_bits(8'hFF, 3, -1, 0, 1'b0, 1'b0, 8'h00);
    clear = 1'b1; enable = 1'b1; sr_in = 1'b1;
    tick;
    clear = 1'b0; enable = 1'b0; sr_in = 1'b0;
    check_zero("mid_clear");
    send_bits(8'h0F, 8, -1, 0, 1'b0, 1'b1, 8'h0F);
    expect_word("after_clear");

    // Unacknowledged word followed by another completion.
    ack_idle;
    send_bits(8'hAA, 8, -1, 0, 1'b0, 1'b1, 8'hAA);
    expect_word("ovr_first");
`ifdef SIPO_OVERRUN_EN
    send_bits(8'h55, 8, -1, 0, 1'b0, 1'b1, 8'hAA);
    expect_word("ovr_dropped");
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (5) tick;
    ack_idle;
    check("ovr_sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
`else
    send_bits(8'h55, 8, -1, 0, 1'b0, 1'b1, 8'h55);
    expect_word("ovr_overwrite");
`endif

    // Twenty idle cycles with a held word and a partial word.
    ack_idle;
    send_bits(8'hA5, 8, -1, 0, 1'b0, 1'b1, 8'hA5);
    expect_word("idle_word");
    send_bits(8'h07, 3, -1, 0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      sr_in = 1'($urandom_range(0, 1));
      tick;
      check("idle_p_out", 32'(p_out), 32'hA5);
      check("idle_valid", 32'(out_valid), 32'd1);
      check("idle_bit_cnt", 32'(bit_cnt), 32'd3);
    end

    // rst and clear together.
    rst = 1'b1; clear = 1'b1; enable = 1'b1; out_ack = 1'b1;
    tick;
    rst = 1'b0; clear = 1'b0; enable = 1'b0; out_ack = 1'b0;
    check_zero("rst_and_clear");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d queued words expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_shift_register.md
SIPO_SHIFT_REGISTER -- requirements
Module: sipo_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the word length in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port clear, input, 1, a synchronous, active-high soft clear.
REQ-005 SHALL have port enable, input, 1, which qualifies sampling of sr_in on the current edge.
REQ-006 SHALL have port sr_in, input, 1, the serial data bit, LSB of each word first.
REQ-007 SHALL have port out_ack, input, 1, the consumer acknowledge for the current word.
REQ-008 SHALL have port p_out, output, WIDTH, the last completed word.
REQ-009 SHALL have port out_valid, output, 1, asserted while p_out holds an unacknowledged word.
REQ-010 SHALL have port bit_cnt, output, clog2(WIDTH), the number of bits accumulated in the current word.
REQ-011 SHALL have port overrun, output, 1, a sticky overrun flag; this port is present only with SIPO_OVERRUN_EN.

Function
REQ-012 SHALL shift the internal shift register right on each edge where enable=1, inserting sr_in at bit WIDTH-1, and SHALL increment bit_cnt on the same edge.
REQ-013 SHALL hold the shift register and bit_cnt unchanged on each edge where enable=0.
REQ-014 SHALL place the bit sampled in the k-th enabled cycle (k=0..WIDTH-1) at p_out[k].
REQ-015 SHALL, on the edge that samples bit WIDTH-1, wrap bit_cnt to 0, copy the completed word (including that bit) into p_out, and set out_valid; p_out and out_valid SHALL be visible on the following cycle (latency 1 edge after the last bit).
REQ-016 SHALL keep p_out stable while out_valid=1, and SHALL clear out_valid on an edge where out_ack=1 and no word completes.
REQ-017 SHALL ignore out_ack while out_valid=0.
REQ-018 SHALL, when out_ack=1 and a word completes on the same edge, load the new word and keep out_valid=1.
REQ-019 SHALL continue accumulating serial bits while out_valid=1; no backpressure is applied to the serial side.
REQ-020 SHALL, when a word completes with out_valid=1 and out_ack=0, overwrite p_out with the new word and keep out_valid=1 if SIPO_OVERRUN_EN is undefined.
REQ-021 SHALL give clear the same effect as rst, with rst taking priority when both are asserted.

Reset
REQ-022 SHALL, on an edge where rst=1, set the shift register to 0, bit_cnt to 0, p_out to 0, out_valid to 0, and overrun (if present) to 0, regardless of enable and out_ack.
REQ-023 SHALL discard a partially received word when rst or clear is asserted mid-word; the next enabled bit is then bit 0 of a new word.
REQ-024 SHALL leave all outputs defined (0) from the first edge with rst=1, with no combinational path from rst to any output.

Configuration
REQ-025 SHALL implement the overrun feature only when the macro SIPO_OVERRUN_EN is defined.
REQ-026 SHALL, with SIPO_OVERRUN_EN defined, drop the new word, leave p_out unchanged and set overrun=1 when a word completes with out_valid=1 and out_ack=0.
REQ-027 SHALL hold overrun at 1 until rst or clear, and SHALL NOT set it when out_ack=1 on the completing edge.
REQ-028 SHALL, with SIPO_OVERRUN_EN undefined, omit the overrun port and behave per REQ-020.

Structure
REQ-029 SHALL take WIDTH_DEFAULT (8) and the function for the bit_cnt width from shared package sipo_pkg.
REQ-030 SHALL place bit counting and the wrap/last-bit strobe in sub-module sipo_bit_counter (ports clk, rst, clear, enable, bit_cnt, last).

Verification
REQ-031 SHALL verify that, after reset and with enable=1 for 8 cycles, sr_in=0,1,0,1,0,1,0,1 gives p_out=8'hAA and out_valid=1 one edge after the 8th bit, with bit_cnt=0.
REQ-032 SHALL verify that a 3-cycle enable gap mid-word is tolerated: the stream 8'h3C (LSB first) with enable low between bits 3 and 4 still yields p_out=8'h3C.
REQ-033 SHALL verify that out_ack=1 for one cycle after 8'hAA clears out_valid, and that out_ack coincident with completion of 8'h55 leaves out_valid=1 with p_out=8'h55.
REQ-034 SHALL verify that rst=1 asserted after 5 bits sets bit_cnt to 0; the next 8 bits 8'hF0 then give p_out=8'hF0, with no leftover bits present.
REQ-035 SHALL verify overrun handling when 8'hAA is left unacknowledged and 8'h55 then completes: with SIPO_OVERRUN_EN, p_out=8'hAA and overrun=1 until clear; without it, p_out=8'h55.
REQ-036 SHALL verify that clear and rst asserted together give the REQ-022 reset state, and that enable=0 for 20 cycles leaves all outputs unchanged.
